// File: rtl/ysyx_22040750_ifu_fetch_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   RESET_PC  : PC loaded on reset
//   INST_NOP  : canonical RV nop (addi x0,x0,0)
//   PC_W      : architectural PC width
//   IADDR_W   : icache address width
//   BUF_DEPTH : fetch buffer entries (structural, fixed at 2)
//   fetch_ent_t : one buffered {pc, inst} pair
package ysyx_22040750_defs;
    localparam int              PC_W      = 64;
    localparam int              IADDR_W   = 32;
    localparam int              INST_W    = 32;
    localparam logic [63:0]     RESET_PC  = 64'h0000_0000_8000_0000;
    localparam logic [31:0]     INST_NOP  = 32'h0000_0013;
    localparam logic [2:0]      BUF_DEPTH = 3'd2;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_ent_t;
endpackage

// File: rtl/ysyx_22040750_ifu_fetch_buf.sv
// Two-entry FIFO of fetched {pc, inst} pairs feeding ID.
//   I_clk, I_rst   : clock, synchronous active-high reset
//   push_i/ent_i   : enqueue one entry
//   deq_i          : pop the head (caller guarantees occ_o != 0)
//   flush_i        : empty the FIFO; overrides push
//   occ_o          : occupancy 0..2
//   head_o         : oldest entry (entry 0)
module ysyx_22040750_ifu_buf
    import ysyx_22040750_defs::*;
(
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic       push_i,
    input  fetch_ent_t ent_i,
    input  logic       deq_i,
    input  logic       flush_i,
    output logic [1:0] occ_o,
    output fetch_ent_t head_o
);
    fetch_ent_t ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0] occ_q, occ_d;

    // Entry 0 is always the head; a pop shifts entry 1 down.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        if (flush_i) begin
            occ_d = 2'd0;
        end else begin
            case ({push_i, deq_i})
                2'b10: begin
                    if (occ_q == 2'd0) ent0_d = ent_i;
                    else               ent1_d = ent_i;
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    ent0_d = ent1_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        ent0_d = ent_i;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = ent_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = ent0_q;

    // The issue rule in the parent reserves a slot for every accepted request.
    a_no_push_full: assert property (@(posedge I_clk) disable iff (I_rst)
        !(push_i && !flush_i && occ_q == 2'd2));
endmodule

// File: rtl/ysyx_22040750_ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests
// to the icache, buffers returned instructions and hands them to ID.
//   I_clk, I_rst          : clock, synchronous active-high reset
//   O_icache_addr/rd_req  : fetch request (accept = rd_req & rd_ready)
//   I_icache_inst/rvalid  : single-cycle response, cannot be stalled
//   I_redirect_valid/pc   : redirect pulse from EX (highest priority)
//   O_id_valid/inst/pc    : buffer head to ID (deq = valid & ready)
module ysyx_22040750_ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        I_clk,
    input  logic        I_rst,
    output logic [31:0] O_icache_addr,
    output logic        O_icache_rd_req,
    input  logic        I_icache_rd_ready,
    input  logic [31:0] I_icache_inst,
    input  logic        I_icache_rvalid,
    input  logic        I_redirect_valid,
    input  logic [63:0] I_redirect_pc,
    output logic        O_id_valid,
    input  logic        I_id_ready,
    output logic [31:0] O_id_inst,
    output logic [63:0] O_id_pc
);
    import ysyx_22040750_defs::*;

    logic [63:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
    logic        inflight_q, inflight_d, drop_q, drop_d;
    logic [1:0]  occ;
    fetch_ent_t  head;
    logic        deq, accept, push;
    logic [2:0]  occ_proj;
    logic        unused_redirect_lsb;

    // No compressed instructions: redirect target low bits are ignored.
    assign unused_redirect_lsb = ^I_redirect_pc[1:0];

    assign O_id_valid = (occ != 2'd0) & ~I_redirect_valid & ~I_rst;
    assign deq        = O_id_valid & I_id_ready;

    // Slots already spoken for (buffered + in flight) after this cycle's pop.
    assign occ_proj = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, deq};

    assign O_icache_rd_req = ~I_rst & ~I_redirect_valid
                           & (~inflight_q | I_icache_rvalid)
                           & (occ_proj < BUF_DEPTH);
    assign O_icache_addr   = pc_q[31:0];
    assign accept          = O_icache_rd_req & I_icache_rd_ready;

    assign push = I_icache_rvalid & inflight_q & ~drop_q & ~I_redirect_valid;

    always_comb begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = inflight_q;
        drop_d        = drop_q;
        if (I_redirect_valid) begin
            pc_d = {I_redirect_pc[63:2], 2'b00};
            if (I_icache_rvalid) begin
                // Response in the redirect cycle is simply thrown away.
                inflight_d = 1'b0;
                drop_d     = 1'b0;
            end else if (inflight_q) begin
                // Keep inflight set so no new request goes out before the stale one lands.
                drop_d = 1'b1;
            end
        end else begin
            if (I_icache_rvalid & inflight_q) begin
                inflight_d = 1'b0;
                drop_d     = 1'b0;
            end
            if (accept) begin
                pc_d          = pc_q + 64'd4;
                inflight_pc_d = pc_q;
                inflight_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            drop_q        <= drop_d;
        end
    end

    ysyx_22040750_ifu_buf u_buf (
        .I_clk   (I_clk),
        .I_rst   (I_rst),
        .push_i  (push),
        .ent_i   ('{pc: inflight_pc_q, inst: I_icache_inst}),
        .deq_i   (deq),
        .flush_i (I_redirect_valid),
        .occ_o   (occ),
        .head_o  (head)
    );

    assign O_id_inst = head.inst;
    assign O_id_pc   = head.pc;
endmodule

// File: tb/tb_ysyx_22040750_ifu_fetch.sv
module tb_ysyx_22040750_ifu_fetch;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        I_clk = 1'b0;
    logic        I_rst = 1'b1;
    logic [31:0] O_icache_addr;
    logic        O_icache_rd_req;
    logic        I_icache_rd_ready = 1'b0;
    logic [31:0] I_icache_inst = '0;
    logic        I_icache_rvalid = 1'b0;
    logic        I_redirect_valid = 1'b0;
    logic [63:0] I_redirect_pc = '0;
    logic        O_id_valid;
    logic        I_id_ready = 1'b0;
    logic [31:0] O_id_inst;
    logic [63:0] O_id_pc;

    ysyx_22040750_ifu_fetch #(.RESET_PC(RST_PC)) dut (
        .I_clk(I_clk), .I_rst(I_rst),
        .O_icache_addr(O_icache_addr), .O_icache_rd_req(O_icache_rd_req),
        .I_icache_rd_ready(I_icache_rd_ready), .I_icache_inst(I_icache_inst),
        .I_icache_rvalid(I_icache_rvalid), .I_redirect_valid(I_redirect_valid),
        .I_redirect_pc(I_redirect_pc), .O_id_valid(O_id_valid),
        .I_id_ready(I_id_ready), .O_id_inst(O_id_inst), .O_id_pc(O_id_pc)
    );

    always #5 I_clk = ~I_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: ID must see consecutive word PCs from the last reset/redirect target.
    logic [63:0] exp_q[$];
    logic [63:0] gen_pc;

    // icache model state
    bit          pend = 0, pend_stray = 0;
    int          pend_lat = 0;
    logic [31:0] pend_addr = '0;
    bit          acc_s = 0;
    logic [31:0] acc_addr_s = '0;

    // stimulus knobs
    int          force_lat = 1, idr_mode = 1, rdy_pct = 100, redir_pmil = 0, rst_pmil = 0;
    int          rst_req = 0;
    bit          redir_req = 0, redir_on_rv = 0;
    logic [63:0] redir_tgt = '0;

    // monitor state
    bit          first_chk = 0, need_req_next = 0, nrn_prev = 0;
    logic [31:0] first_addr = '0;
    bit          p_req = 0, p_rdy = 0, p_redir = 0, p_rst = 1;
    logic [31:0] p_addr = '0;
    int          deq_cnt = 0;

    function automatic logic [31:0] fi(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F ^ (a << 3);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic restart(input logic [63:0] tgt);
        exp_q.delete();
        gen_pc = {tgt[63:2], 2'b00};
        first_addr = gen_pc[31:0];
        first_chk = 1;
        repeat (8) begin
            exp_q.push_back(gen_pc);
            gen_pc += 64'd4;
        end
    endtask

    task automatic step();
        logic [63:0] tgt;
        bit do_redir;
        @(posedge I_clk);
        #1;
        if (acc_s) begin
            pend = 1; pend_stray = 0; pend_addr = acc_addr_s;
            pend_lat = (force_lat > 0) ? force_lat :
                       (($urandom_range(0, 99) < 70) ? 1 : int'($urandom_range(2, 10)));
        end
        I_icache_rvalid = 1'b0;
        I_icache_inst   = $urandom;
        if (pend) begin
            if (pend_lat <= 1) begin
                pend = 0;
                I_icache_rvalid = 1'b1;
                I_icache_inst   = pend_stray ? 32'hDEAD_BEEF : fi(pend_addr);
            end else begin
                pend_lat--;
            end
        end
        I_icache_rd_ready = !pend && ($urandom_range(0, 99) < rdy_pct);
        I_id_ready = (idr_mode == 1) ? 1'b1 : (idr_mode == 2) ? 1'b0 : ($urandom_range(0, 99) < 70);
        I_rst = 1'b0;
        I_redirect_valid = 1'b0;
        I_redirect_pc = {$urandom, $urandom};
        need_req_next = 0;
        if (rst_req > 0 || $urandom_range(0, 999) < rst_pmil) begin
            if (rst_req > 0) rst_req--;
            I_rst = 1'b1;
            if (pend) pend_stray = 1;
            restart(RST_PC);
        end else begin
            do_redir = 0;
            tgt = '0;
            if (redir_req) begin
                do_redir = 1; tgt = redir_tgt; redir_req = 0;
            end else if (redir_on_rv && I_icache_rvalid) begin
                do_redir = 1; tgt = redir_tgt; redir_on_rv = 0;
            end else if ($urandom_range(0, 999) < redir_pmil) begin
                do_redir = 1;
                tgt = {($urandom_range(0, 3) == 0) ? $urandom : 32'h0,
                       32'h8000_0000 | ($urandom & 32'h000F_FFFF)};
            end
            if (do_redir) begin
                I_redirect_valid = 1'b1;
                I_redirect_pc = tgt;
                need_req_next = !pend;
                restart(tgt);
            end
        end
    endtask

    always @(negedge I_clk) begin
        logic [63:0] e;
        if (I_rst) begin
            if (p_rst) begin
                chk("rst_id_valid", 64'(O_id_valid), 64'd0);
                chk("rst_rd_req", 64'(O_icache_rd_req), 64'd0);
                chk("rst_id_inst", 64'(O_id_inst), 64'd0);
                chk("rst_id_pc", O_id_pc, 64'd0);
            end
            nrn_prev = 0;
        end else if (I_redirect_valid) begin
            chk("redir_id_valid", 64'(O_id_valid), 64'd0);
            chk("redir_rd_req", 64'(O_icache_rd_req), 64'd0);
            nrn_prev = need_req_next;
        end else begin
            if (nrn_prev) chk("req_after_redir", 64'(O_icache_rd_req), 64'd1);
            nrn_prev = 0;
            if (first_chk && O_icache_rd_req) begin
                chk("first_addr", 64'(O_icache_addr), 64'(first_addr));
                first_chk = 0;
            end
            if (p_req && !p_rdy && !p_redir && !p_rst)
                chk("addr_stable", 64'(O_icache_addr), 64'(p_addr));
            if (pend && !pend_stray && !I_icache_rvalid)
                chk("single_outstanding", 64'(O_icache_rd_req), 64'd0);
            if (O_id_valid && I_id_ready) begin
                deq_cnt++;
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sb_underflow: got pc %h expected none", O_id_pc);
                end else begin
                    e = exp_q.pop_front();
                    exp_q.push_back(gen_pc);
                    gen_pc += 64'd4;
                    chk("id_pc", O_id_pc, e);
                    chk("id_inst", 64'(O_id_inst), 64'(fi(e[31:0])));
                end
            end
        end
        acc_s      = O_icache_rd_req && I_icache_rd_ready && !I_rst;
        acc_addr_s = O_icache_addr;
        p_req = O_icache_rd_req; p_rdy = I_icache_rd_ready;
        p_redir = I_redirect_valid; p_rst = I_rst; p_addr = O_icache_addr;
    end

    task automatic wait_long_miss(input string nm);
        int k;
        k = 0;
        do begin step(); k++; end while (!(pend && pend_lat == 9) && k < 50);
        if (k >= 50) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: got no long miss expected one within 50 cycles", nm);
        end
    endtask

    initial begin
        int c0;
        // 1: reset then always-hit streaming, one inst per cycle
        rst_req = 3; idr_mode = 1; rdy_pct = 100; force_lat = 1;
        repeat (3) step();
        repeat (8) step();
        c0 = deq_cnt;
        repeat (20) step();
        chk("hit_throughput", 64'(deq_cnt - c0), 64'd20);
        // 2: ID stall fills the buffer and blocks requests
        idr_mode = 2;
        repeat (6) step();
        #2 chk("full_no_req", 64'(O_icache_rd_req), 64'd0);
        idr_mode = 1;
        repeat (10) step();
        // 3: redirect three cycles into a long miss
        force_lat = 10;
        wait_long_miss("miss_redir");
        repeat (2) step();
        force_lat = 1;
        redir_req = 1; redir_tgt = 64'h0000_0000_8000_1000;
        repeat (30) step();
        // 4: redirect coinciding with rvalid while buffer holds one entry
        redir_on_rv = 1; redir_tgt = 64'h0000_0000_8000_3000;
        repeat (20) step();
        // 5: misaligned redirect target
        redir_req = 1; redir_tgt = 64'h0000_0000_8000_2006;
        repeat (20) step();
        // 64-bit PC wrap
        redir_req = 1; redir_tgt = 64'hFFFF_FFFF_FFFF_FFF8;
        repeat (20) step();
        // 6: reset mid-miss, stray response afterwards
        force_lat = 10;
        wait_long_miss("miss_rst");
        repeat (2) step();
        force_lat = 1;
        rst_req = 1;
        repeat (40) step();
        // randomized traffic
        force_lat = 0; rdy_pct = 75; idr_mode = 0; redir_pmil = 20; rst_pmil = 3;
        repeat (3000) step();
        redir_pmil = 0; rst_pmil = 0; idr_mode = 1; rdy_pct = 100; force_lat = 1;
        repeat (30) step();
        chk("delivered_enough", 64'(deq_cnt > 500), 64'd1);
        @(negedge I_clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
